// File: rtl/deser_rr_arbiter.sv
// deser_rr_arbiter: round-robin arbiter that shares one serial deserializer
// between REQ_N serial sources. It grants a whole DATA_W-bit word at a time,
// forwards the grantee's bit/valid stream with zero latency, tags each
// finished word with its source index, then rotates priority.
// Optional stall timeout: define ARB_TIMEOUT_EN to enable abort_o.
module deser_rr_arbiter #(
  parameter int REQ_N       = 4,
  parameter int DATA_W      = 16,
  parameter int SRC_W       = $clog2(REQ_N),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             srst_n_i,
  input  logic [REQ_N-1:0] req_i,
  input  logic [REQ_N-1:0] data_i,
  input  logic [REQ_N-1:0] data_val_i,
  output logic [REQ_N-1:0] gnt_o,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic [SRC_W-1:0] src_o,
  output logic             word_done_o,
  output logic [SRC_W-1:0] word_src_o,
  output logic             busy_o,
  output logic             abort_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  typedef struct packed {
    logic             hit;
    logic [SRC_W-1:0] idx;
  } pick_t;

  state_t           r_state;
  logic [REQ_N-1:0] r_gnt;
  logic [SRC_W-1:0] r_src;
  logic [SRC_W-1:0] r_ptr;
  logic [SRC_W-1:0] r_word_src;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fwd_val;
  logic             w_last;
  logic [SRC_W-1:0] w_next_ptr;
  logic [SRC_W-1:0] w_arb_ptr;
  pick_t            w_pick;

  // First requester at or after ptr, wrapping; lowest offset wins.
  function automatic pick_t rr_pick(input logic [REQ_N-1:0] req,
                                    input logic [SRC_W-1:0] ptr);
    pick_t p;
    int    idx;
    p.hit = 1'b0;
    p.idx = '0;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % REQ_N;
      if (req[idx[SRC_W-1:0]]) begin
        p.hit = 1'b1;
        p.idx = idx[SRC_W-1:0];
      end
    end
    return p;
  endfunction

  // Forwarding path, word-end detect and arbitration request.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_fwd_val  = (r_state == S_BUSY) && data_val_i[r_src];
    w_last     = w_fwd_val && (r_cnt == CNT_W'(DATA_W - 1));
    w_next_ptr = (r_src == SRC_W'(REQ_N - 1)) ? '0 : r_src + SRC_W'(1);
    // At word end arbitrate from the rotated pointer so the next grant lands
    // without an IDLE bubble; in IDLE use the stored pointer.
    w_arb_ptr  = (r_state == S_BUSY) ? w_next_ptr : r_ptr;
    w_pick     = rr_pick(req_i, w_arb_ptr);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
  logic [ST_W-1:0] r_stall;
  logic            r_abort;
  logic            w_timeout;
  assign w_timeout = (r_state == S_BUSY) && !w_fwd_val &&
                     (r_stall == ST_W'(TIMEOUT_CYC - 1));
  assign abort_o   = r_abort;
`else
  assign abort_o   = 1'b0;
`endif

  // Arbiter FSM: grant, count forwarded bits, rotate, optional timeout.
  // NOTE: sequential state uses non-blocking (<=) so all registers update together.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_src      <= '0;
      r_ptr      <= '0;
      r_word_src <= '0;
      r_cnt      <= '0;
`ifdef ARB_TIMEOUT_EN
      r_stall    <= '0;
      r_abort    <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_abort <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_pick.hit) begin
            r_state <= S_BUSY;
            r_gnt   <= REQ_N'(1) << w_pick.idx;
            r_src   <= w_pick.idx;
            r_cnt   <= '0;
`ifdef ARB_TIMEOUT_EN
            r_stall <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (w_last) begin
            r_word_src <= r_src;
            r_ptr      <= w_next_ptr;
            r_cnt      <= '0;
`ifdef ARB_TIMEOUT_EN
            r_stall    <= '0;
`endif
            if (w_pick.hit) begin
              r_gnt <= REQ_N'(1) << w_pick.idx;
              r_src <= w_pick.idx;
            end else begin
              r_state <= S_IDLE;
              r_gnt   <= '0;
              r_src   <= '0;
            end
          end else if (w_fwd_val) begin
            r_cnt <= r_cnt + CNT_W'(1);
`ifdef ARB_TIMEOUT_EN
            r_stall <= '0;
          end else if (w_timeout) begin
            // Stalled grantee: drop it, skip past it, no word_done.
            r_abort <= 1'b1;
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_src   <= '0;
            r_cnt   <= '0;
            r_stall <= '0;
            r_ptr   <= w_next_ptr;
          end else begin
            r_stall <= r_stall + ST_W'(1);
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_o          = r_gnt;
  assign src_o          = r_src;
  assign busy_o         = (r_state == S_BUSY);
  assign ser_data_o     = (r_state == S_BUSY) && data_i[r_src];
  assign ser_data_val_o = w_fwd_val;
  assign word_done_o    = w_last;
  assign word_src_o     = r_word_src;

endmodule

// File: tb/tb_deser_rr_arbiter.sv
// Self-checking bench for deser_rr_arbiter: randomized words and noise,
// checked against a spec-level round-robin and MSB-first word model.
module tb_deser_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic         clk_i = 1'b0;
  logic         srst_n_i;
  logic [N-1:0] req_i, data_i, data_val_i;
  logic [N-1:0] gnt_o;
  logic         ser_data_o, ser_data_val_o, word_done_o, busy_o, abort_o;
  logic [1:0]   src_o, word_src_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int m_ptr    = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;

  deser_rr_arbiter #(.REQ_N(N), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .srst_n_i(srst_n_i), .req_i(req_i), .data_i(data_i),
    .data_val_i(data_val_i), .gnt_o(gnt_o), .ser_data_o(ser_data_o),
    .ser_data_val_o(ser_data_val_o), .src_o(src_o), .word_done_o(word_done_o),
    .word_src_o(word_src_o), .busy_o(busy_o), .abort_o(abort_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  // Round-robin rule: first requester from ptr upward with wrap, -1 if none.
  function automatic int ref_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Check the grant the model predicts, as seen right now.
  task automatic check_grant(input string name, input int exp);
    n_checks++;
    if (gnt_o !== onehot(exp) || busy_o !== (exp >= 0) ||
        (exp >= 0 && src_o !== 2'(exp)))
      $display("FAIL %s: gnt=%b busy=%b src=%0d, required gnt=%b", name,
               gnt_o, busy_o, src_o, onehot(exp));
    else n_pass++;
  endtask

  // Drive n_bits of word w (MSB first) from the grantee; optional gap of
  // gap_len idle cycles before bit gap_at; optional random noise on others.
  task automatic run_word(input int src, input logic [DW-1:0] w, input int n_bits,
                          input int gap_at, input int gap_len, input bit noise);
    logic [DW-1:0] acc;
    int  i, g;
    bit  in_gap;
    acc = '0; i = 0; g = 0;
    while (i < n_bits) begin
      in_gap = (i == gap_at) && (g < gap_len);
      data_i     = noise ? N'($urandom) : '0;
      data_val_i = noise ? N'($urandom) : '0;
      data_val_i[src] = !in_gap;
      data_i[src]     = in_gap ? 1'($urandom) : w[DW-1-i];
      @(negedge clk_i);
      n_checks++;
      if (ser_data_val_o !== !in_gap || (!in_gap && ser_data_o !== w[DW-1-i]) ||
          abort_o !== 1'b0)
        $display("FAIL fwd src%0d bit%0d: val=%b data=%b abort=%b, required val=%b data=%b",
                 src, i, ser_data_val_o, ser_data_o, abort_o, !in_gap, w[DW-1-i]);
      else n_pass++;
      if (ser_data_val_o) acc = {acc[DW-2:0], ser_data_o};
      n_checks++;
      if (word_done_o !== (!in_gap && i == DW - 1))
        $display("FAIL word_done src%0d bit%0d: got %b", src, i, word_done_o);
      else n_pass++;
      if (word_done_o) begin
        done_cnt++;
        last_done_cyc = cyc;
        n_checks++;
        if (acc !== w) $display("FAIL deser_word src%0d: got %h, required %h", src, acc, w);
        else n_pass++;
      end
      tick();
      if (in_gap) g++; else i++;
    end
    data_i = '0; data_val_i = '0;
    if (n_bits == DW) begin
      m_ptr = (src + 1) % N;
      n_checks++;
      if (word_src_o !== 2'(src))
        $display("FAIL word_src: got %0d, required %0d", word_src_o, src);
      else n_pass++;
    end
  endtask

  task automatic do_reset();
    srst_n_i = 1'b0;
    tick();
    srst_n_i = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    req_i = '0; data_i = '1; data_val_i = '1; srst_n_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    n_checks++;
    if (gnt_o !== 0 || busy_o !== 0 || src_o !== 0 || word_src_o !== 0 ||
        word_done_o !== 0 || abort_o !== 0 || ser_data_o !== 0 || ser_data_val_o !== 0)
      $display("FAIL reset_state: gnt=%b busy=%b src=%0d wsrc=%0d done=%b abort=%b sd=%b sv=%b, required all 0",
               gnt_o, busy_o, src_o, word_src_o, word_done_o, abort_o, ser_data_o, ser_data_val_o);
    else n_pass++;
    data_i = '0; data_val_i = '0;
    tick();
    srst_n_i = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_single_word();
    req_i = 4'b0010;
    @(negedge clk_i);
    check_grant("single_pre_grant", -1);
    tick();
    check_grant("single_grant", ref_pick(req_i, m_ptr));
    req_i = '0;
    done_cnt = 0;
    run_word(1, 16'hA5C3, DW, -1, 0, 1'b0);
    n_checks++;
    if (done_cnt !== 1) $display("FAIL single_done_count: got %0d, required 1", done_cnt);
    else n_pass++;
    check_grant("single_after", -1);
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    req_i = 4'b1111;
    tick();
    exp = ref_pick(req_i, m_ptr);
    for (int w = 0; w < 5; w++) begin
      check_grant($sformatf("rr_grant%0d", w), exp);
      if (w == 4) req_i = '0;  // grantee drops req mid-word: no effect
      run_word(exp, DW'($urandom), DW, -1, 0, 1'b0);
      exp = ref_pick(req_i, m_ptr);
    end
    check_grant("rr_after", exp);
  endtask

  task automatic test_idle_gaps();
    int exp;
    req_i = 4'b0100;
    tick();
    exp = ref_pick(4'b0100, m_ptr);
    check_grant("gap_grant", exp);
    req_i = 4'b0101;
    done_cnt = 0;
    run_word(2, DW'($urandom), DW, 8, 5, 1'b1);
    n_checks++;
    if (done_cnt !== 1) $display("FAIL gap_done_count: got %0d, required 1", done_cnt);
    else n_pass++;
    exp = ref_pick(req_i, m_ptr);
    check_grant("gap_next_grant", exp);
    req_i = '0;
    run_word(exp, DW'($urandom), DW, -1, 0, 1'b1);
    check_grant("gap_after", -1);
  endtask

  task automatic test_reset_mid_word();
    req_i = 4'b0010;
    tick();
    check_grant("mid_grant", ref_pick(req_i, m_ptr));
    req_i = '0;
    run_word(1, DW'($urandom), 10, -1, 0, 1'b0);
    srst_n_i = 1'b0;
    data_i = '1; data_val_i = 4'b0010;
    tick();
    srst_n_i = 1'b1;
    m_ptr = 0;
    @(negedge clk_i);
    n_checks++;
    if (gnt_o !== 0 || busy_o !== 0 || src_o !== 0 || word_src_o !== 0 ||
        word_done_o !== 0 || abort_o !== 0 || ser_data_val_o !== 0 || ser_data_o !== 0)
      $display("FAIL mid_reset_state: gnt=%b busy=%b src=%0d wsrc=%0d done=%b sv=%b, required all 0",
               gnt_o, busy_o, src_o, word_src_o, word_done_o, ser_data_val_o);
    else n_pass++;
    data_i = '0; data_val_i = '0;
    req_i = 4'b1000;
    tick();
    check_grant("mid_new_grant", ref_pick(req_i, m_ptr));
    req_i = '0;
    run_word(3, DW'($urandom), DW, -1, 0, 1'b0);
    check_grant("mid_after", -1);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int exp;
    req_i = 4'b0110;
    tick();
    exp = ref_pick(req_i, m_ptr);
    check_grant("to_grant", exp);
    done_cnt = 0;
    run_word(exp, DW'($urandom), 5, -1, 0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_i);
      n_checks++;
      if (abort_o !== (k == 9) || word_done_o !== 1'b0 || (k == 9 && gnt_o !== '0))
        $display("FAIL timeout_k%0d: abort=%b done=%b gnt=%b, required abort=%b",
                 k, abort_o, word_done_o, gnt_o, (k == 9));
      else n_pass++;
      tick();
    end
    m_ptr = (exp + 1) % N;
    exp = ref_pick(req_i, m_ptr);
    check_grant("to_next_grant", exp);
    n_checks++;
    if (abort_o !== 1'b0 || done_cnt !== 0)
      $display("FAIL timeout_pulse: abort=%b done_cnt=%0d, required 0/0", abort_o, done_cnt);
    else n_pass++;
    req_i = '0;
    run_word(exp, DW'($urandom), DW, -1, 0, 1'b0);
    check_grant("to_after", -1);
  endtask
`else
  task automatic test_timeout();
    int exp;
    req_i = 4'b0110;
    tick();
    exp = ref_pick(req_i, m_ptr);
    check_grant("nto_grant", exp);
    req_i = 4'b0100;
    run_word(exp, DW'($urandom), DW, 5, 20, 1'b0);  // abort_o checked 0 each cycle
    exp = ref_pick(req_i, m_ptr);
    check_grant("nto_next", exp);
    req_i = '0;
    run_word(exp, DW'($urandom), DW, -1, 0, 1'b0);
    check_grant("nto_after", -1);
  endtask
`endif

  task automatic test_back_to_back();
    int prev;
    do_reset();
    req_i = 4'b0001;
    tick();
    done_cnt = 0;
    prev = 0;
    for (int w = 0; w < 3; w++) begin
      check_grant($sformatf("b2b_grant%0d", w), ref_pick(req_i, m_ptr));
      if (w == 2) req_i = '0;
      run_word(0, DW'($urandom), DW, -1, 0, 1'b0);
      if (w > 0) begin
        n_checks++;
        if (last_done_cyc - prev !== DW)
          $display("FAIL b2b_spacing%0d: got %0d, required %0d", w, last_done_cyc - prev, DW);
        else n_pass++;
      end
      prev = last_done_cyc;
    end
    n_checks++;
    if (done_cnt !== 3) $display("FAIL b2b_done_count: got %0d, required 3", done_cnt);
    else n_pass++;
    check_grant("b2b_after", -1);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_idle_gaps();
    test_reset_mid_word();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard bound so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/deser_rr_arbiter.md
Name: deser_rr_arbiter

Overview:
Round-robin arbiter that shares one serial deserializer between REQ_N serial sources.
- Grants a whole DATA_W-bit word to one requester and forwards its bit/valid stream to the shared deserializer.
- Never switches sources mid-word, then rotates priority.
- Tags each completed word with its source index so downstream logic can route the deserialized word.

Parameters:
REQ_N, 4, number of serial requesters (2..16)
DATA_W, 16, bits per word; must match the shared deserializer's word width
SRC_W, $clog2(REQ_N), width of source index (derived; do not override)
TIMEOUT_CYC, 64, stall limit in cycles; used only when ARB_TIMEOUT_EN is defined

Ports:
clk_i  in  1  single clock; all logic on its rising edge
srst_n_i  in  1  synchronous reset, active-low
req_i  in  REQ_N  per-source request; level, held until granted
data_i  in  REQ_N  per-source serial data bit
data_val_i  in  REQ_N  per-source bit-valid
gnt_o  out  REQ_N  one-hot grant, registered
ser_data_o  out  1  forwarded bit to the deserializer's data_i
ser_data_val_o  out  1  forwarded valid to the deserializer's data_val_i
src_o  out  SRC_W  index of current grantee; valid while busy_o
word_done_o  out  1  one-cycle pulse on the cycle the last bit of a word is forwarded
word_src_o  out  SRC_W  source of the last completed word; updated with word_done_o, held otherwise
busy_o  out  1  grant active
abort_o  out  1  one-cycle pulse on timeout; constant 0 when the feature is compiled out

Behaviour:
- Reset (srst_n_i=0 at a clock edge): state=IDLE; gnt_o, src_o, word_src_o, word_done_o, busy_o, abort_o all 0; bit counter 0; priority pointer 0. ser_data_o and ser_data_val_o are 0 because they are gated by the grant.
- Reset mid-word aborts the word silently. The owner must also reset the deserializer.
- States: IDLE, BUSY.
- IDLE:
  - If any req_i bit is set, pick the first set bit searching from pointer upward with wrap (pointer, pointer+1, ..., REQ_N-1, 0, ...).
  - Next cycle: gnt_o one-hot, src_o = index, busy_o=1, state BUSY, counter 0.
  - If no req_i bit is set, stay in IDLE.
- BUSY:
  - Forwarding is combinational, zero latency: ser_data_o = data_i[src_o], ser_data_val_o = data_val_i[src_o].
  - data_val_i from non-granted sources is ignored.
  - Counter increments on each forwarded valid. Counter width is $clog2(DATA_W); it counts 0..DATA_W-1.
  - Idle cycles (valid=0) inside a word are allowed, with no limit unless ARB_TIMEOUT_EN is defined.
  - The grantee dropping req_i mid-word has no effect; the grant holds until the word completes.
- Word end (valid forwarded with counter==DATA_W-1):
  - Same cycle: word_done_o=1 and word_src_o <= src_o (visible the next cycle, aligned with the deserializer's valid, which rises one cycle after the last bit).
  - Counter wraps to 0.
  - Pointer <= src_o+1, wrapping REQ_N-1 to 0.
  - Next cycle: arbitration runs from the new pointer over current req_i. If a request exists, the new grant is seen in gnt_o the next cycle with no IDLE bubble. Otherwise go to IDLE with gnt_o=0.
- The previous grantee may be re-granted immediately only if no other source requests.
- Only one grant at a time; gnt_o is always one-hot or zero.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A stall counter clears on every forwarded valid and on grant.
  - It increments each BUSY cycle with ser_data_val_o=0.
  - On reaching TIMEOUT_CYC, the next cycle: abort_o pulses 1, the grant drops, the bit counter clears, the pointer advances past the stalled source, and no word_done_o is generated.
  - Integration ORs abort_o into the deserializer reset so its bit count realigns.
- Not defined: no stall counter; abort_o tied to 0; grant holds indefinitely.

Test Plan:
1. Reset, then req_i=4'b0010 with 16 back-to-back valid bits 0xA5C3 MSB first → gnt_o=4'b0010 one cycle after req; deserializer outputs 0xA5C3; word_done_o pulses once; word_src_o=1; gnt_o=0 afterwards.
2. req_i=4'b1111 held, each source sends one word → grant order 0,1,2,3,0; word_src_o sequence 0,1,2,3; no IDLE cycle between words.
3. Grantee 2 inserts 5 idle cycles after bit 7 while source 0 toggles data_val_i → word from source 2 is intact; source 0 bits never appear on ser_data_o; word_done_o pulses only after the 16th valid.
4. srst_n_i=0 for one cycle after bit 9 of a word → all outputs 0 the next cycle; pointer 0; a new request from source 3 is granted cleanly.
5. ARB_TIMEOUT_EN with TIMEOUT_CYC=8: grantee 1 stops after bit 4 → abort_o pulses once after 8 stall cycles; no word_done_o; pending source 2 is granted next.
6. Only source 0 requests continuously for 3 words → re-granted each time; exactly three word_done_o pulses, 16 valids apart.
